// File: rtl/regs_wr_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regs_wr_arb_pkg;

   typedef logic [4:0]  RegAddrBus;
   typedef logic [31:0] RegBus;

   localparam RegBus ZeroWord = 32'h0000_0000;

   // Identity of whoever owns the write port in a given cycle
   typedef enum logic [1:0] {
      REQ_WB   = 2'd0,
      REQ_LSU  = 2'd1,
      REQ_DBG  = 2'd2,
      REQ_NONE = 2'd3
   } req_id_e;

   localparam int STARVE_MAX_DEF = 8;

endpackage

// File: rtl/regs_wr_arb_if.sv
// Bundle of writer requests, handshake readies and the regs write port.
interface regs_wr_arb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wb_we;
   logic [ADDR_W-1:0] wb_waddr;
   logic [DATA_W-1:0] wb_wdata;

   logic              lsu_valid;
   logic              lsu_ready;
   logic [ADDR_W-1:0] lsu_waddr;
   logic [DATA_W-1:0] lsu_wdata;

   logic              dbg_valid;
   logic              dbg_ready;
   logic [ADDR_W-1:0] dbg_waddr;
   logic [DATA_W-1:0] dbg_wdata;

   logic              regs_we;
   logic [ADDR_W-1:0] regs_waddr;
   logic [DATA_W-1:0] regs_wdata;
   logic              stall_req;

   // Writers side: raises requests, sees readies and the resulting port
   modport master (
      output wb_we, wb_waddr, wb_wdata,
      output lsu_valid, lsu_waddr, lsu_wdata,
      output dbg_valid, dbg_waddr, dbg_wdata,
      input  lsu_ready, dbg_ready,
      input  regs_we, regs_waddr, regs_wdata, stall_req
   );

   // Arbiter side
   modport slave (
      input  wb_we, wb_waddr, wb_wdata,
      input  lsu_valid, lsu_waddr, lsu_wdata,
      input  dbg_valid, dbg_waddr, dbg_wdata,
      output lsu_ready, dbg_ready,
      output regs_we, regs_waddr, regs_wdata, stall_req
   );

endinterface

// File: rtl/regs_wr_arb_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 #(
   parameter logic LAST_INIT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last;

   // Grant selection; a lone requester always wins, a tie goes against last
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Remember which side won the most recent handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= LAST_INIT;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/regs_wr_arb.sv
// Register-file write-port arbiter: WB has absolute priority, LSU and DBG
// share the leftover cycles round-robin, and a starvation counter asks the
// pipeline to pause WB when an LSU/DBG request has waited too long.
module regs_wr_arb
   import regs_wr_arb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input logic         clk,
   input logic         rst,
   regs_wr_arb_if.slave bus
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic              wb_active;
   logic [1:0]        gnt;
   logic              lsu_hs;
   logic              dbg_hs;
   req_id_e           winner;
   logic [7:0]        starve_cnt;
   logic [7:0]        starve_nxt;
   logic              regs_we_q;
   logic [ADDR_W-1:0] regs_waddr_q;
   logic [DATA_W-1:0] regs_wdata_q;
   logic              stall_q;

   assign wb_active = bus.wb_we && (bus.wb_waddr != '0);

   rr_arb2 #(
      .LAST_INIT (1'b1)
   ) u_rr (
      .clk (clk),
      .rst (rst),
      .en  (rst && !wb_active),
      .req ({bus.dbg_valid, bus.lsu_valid}),
      .gnt (gnt)
   );

   assign bus.lsu_ready = gnt[0];
   assign bus.dbg_ready = gnt[1];
   assign lsu_hs        = bus.lsu_valid && gnt[0];
   assign dbg_hs        = bus.dbg_valid && gnt[1];

   assign bus.regs_we    = regs_we_q;
   assign bus.regs_waddr = regs_waddr_q;
   assign bus.regs_wdata = regs_wdata_q;
   assign bus.stall_req  = stall_q;

   // Who owns the port this cycle
   always_comb begin
      winner = REQ_NONE;
      if (wb_active) begin
         winner = REQ_WB;
      end else if (lsu_hs) begin
         winner = REQ_LSU;
      end else if (dbg_hs) begin
         winner = REQ_DBG;
      end
   end

   // Starvation count: grows while WB blocks a pending request, saturating
   always_comb begin
      starve_nxt = starve_cnt;
      if (lsu_hs || dbg_hs || !(bus.lsu_valid || bus.dbg_valid)) begin
         starve_nxt = 8'd0;
      end else if (wb_active && (starve_cnt != STARVE_LIM)) begin
         starve_nxt = starve_cnt + 8'd1;
      end
   end

   // Registered write port; x0 targets are accepted but never written
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_we_q    <= 1'b0;
         regs_waddr_q <= '0;
         regs_wdata_q <= '0;
      end else begin
         case (winner)
            REQ_WB: begin
               regs_we_q    <= 1'b1;
               regs_waddr_q <= bus.wb_waddr;
               regs_wdata_q <= bus.wb_wdata;
            end
            REQ_LSU: begin
               regs_we_q <= (bus.lsu_waddr != '0);
               if (bus.lsu_waddr != '0) begin
                  regs_waddr_q <= bus.lsu_waddr;
                  regs_wdata_q <= bus.lsu_wdata;
               end
            end
            REQ_DBG: begin
               regs_we_q <= (bus.dbg_waddr != '0);
               if (bus.dbg_waddr != '0) begin
                  regs_waddr_q <= bus.dbg_waddr;
                  regs_wdata_q <= bus.dbg_wdata;
               end
            end
            default: regs_we_q <= 1'b0;
         endcase
      end
   end

   // Starvation counter and the stall request it drives
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= 8'd0;
         stall_q    <= 1'b0;
      end else begin
         starve_cnt <= starve_nxt;
         stall_q    <= (starve_nxt == STARVE_LIM);
      end
   end

endmodule

// File: tb/tb_regs_wr_arb.sv
// Self-checking bench for regs_wr_arb: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model of the arbitration rules.
module tb_regs_wr_arb;
   import regs_wr_arb_pkg::*;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int STARVE_MAX = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   regs_wr_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regs_wr_arb #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Requesters must hold a blocked request stable until it is accepted
   lsu_hold: assert property (@(posedge clk) disable iff (!rst)
      (bus.lsu_valid && !bus.lsu_ready) |=> (bus.lsu_valid && $stable(bus.lsu_waddr) && $stable(bus.lsu_wdata)))
      else $error("[TB] protocol violation: LSU request dropped or changed before acceptance");
   dbg_hold: assert property (@(posedge clk) disable iff (!rst)
      (bus.dbg_valid && !bus.dbg_ready) |=> (bus.dbg_valid && $stable(bus.dbg_waddr) && $stable(bus.dbg_wdata)))
      else $error("[TB] protocol violation: DBG request dropped or changed before acceptance");

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.wb_we     = 1'b0;
      bus.wb_waddr  = '0;
      bus.wb_wdata  = '0;
      bus.lsu_valid = 1'b0;
      bus.lsu_waddr = '0;
      bus.lsu_wdata = '0;
      bus.dbg_valid = 1'b0;
      bus.dbg_waddr = '0;
      bus.dbg_wdata = '0;
   endtask

   task automatic test_reset();
      logic [31:0] d0, d1;
      d0 = $urandom;
      d1 = $urandom;
      drive_idle();
      #2 rst = 1'b0;
      bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd3; bus.lsu_wdata = d0;
      bus.dbg_valid = 1'b1; bus.dbg_waddr = 5'd4; bus.dbg_wdata = d1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata, bus.lsu_ready, bus.dbg_ready, bus.stall_req} !== 41'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got we=%b waddr=%h wdata=%h lrdy=%b drdy=%b stall=%b, expected all zero",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata, bus.lsu_ready, bus.dbg_ready, bus.stall_req);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({bus.lsu_ready, bus.dbg_ready} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL reset_first_tie: got lrdy/drdy=%b expected 10", {bus.lsu_ready, bus.dbg_ready});
      end
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata} !== {1'b1, 5'd3, d0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_first_write: got we=%b waddr=%0d wdata=%h expected 1/3/%h",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata, d0);
      end
      bus.lsu_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.lsu_ready, bus.dbg_ready} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL reset_dbg_next: got lrdy/drdy=%b expected 01", {bus.lsu_ready, bus.dbg_ready});
      end
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata} !== {1'b1, 5'd4, d1}) begin
         tests_failed++;
         $display("[TB] FAIL reset_dbg_write: got we=%b waddr=%0d wdata=%h expected 1/4/%h",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata, d1);
      end
      bus.dbg_valid = 1'b0;
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata} !== {1'b0, 5'd4, d1}) begin
         tests_failed++;
         $display("[TB] FAIL idle_hold: got we=%b waddr=%0d wdata=%h expected 0/4/%h",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata, d1);
      end
   endtask

   task automatic test_wb_priority();
      logic [31:0] d;
      d = $urandom;
      bus.wb_we = 1'b1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'hDEADBEEF;
      bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd6; bus.lsu_wdata = d;
      @(negedge clk);
      tests_run++;
      if ({bus.lsu_ready, bus.dbg_ready} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL wb_blocks_lsu: got lrdy/drdy=%b expected 00", {bus.lsu_ready, bus.dbg_ready});
      end
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         tests_failed++;
         $display("[TB] FAIL wb_write: got we=%b waddr=%0d wdata=%h expected 1/5/deadbeef",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata);
      end
      bus.wb_we = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.lsu_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL lsu_after_wb: got lsu_ready=%b expected 1", bus.lsu_ready);
      end
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata} !== {1'b1, 5'd6, d}) begin
         tests_failed++;
         $display("[TB] FAIL lsu_write: got we=%b waddr=%0d wdata=%h expected 1/6/%h",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata, d);
      end
      bus.lsu_valid = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      bus.dbg_valid = 1'b1; bus.dbg_waddr = 5'd4; bus.dbg_wdata = 32'h22;
      tick();
      bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd3; bus.lsu_wdata = 32'h11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if ({bus.lsu_ready, bus.dbg_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            tests_failed++;
            $display("[TB] FAIL rr_grant[%0d]: got lrdy/drdy=%b expected %b", i,
                     {bus.lsu_ready, bus.dbg_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         tick();
         tests_run++;
         if ({bus.regs_we, bus.regs_waddr} !== {1'b1, (i % 2 == 0) ? 5'd3 : 5'd4}) begin
            tests_failed++;
            $display("[TB] FAIL rr_waddr[%0d]: got we=%b waddr=%0d expected 1/%0d", i,
                     bus.regs_we, bus.regs_waddr, (i % 2 == 0) ? 3 : 4);
         end
      end
      bus.lsu_valid = 1'b0;
      tick();
      bus.dbg_valid = 1'b0;
      tick();
   endtask

   task automatic test_x0();
      bus.wb_we = 1'b1; bus.wb_waddr = 5'd0; bus.wb_wdata = $urandom;
      bus.dbg_valid = 1'b1; bus.dbg_waddr = 5'd4; bus.dbg_wdata = 32'h22;
      @(negedge clk);
      tests_run++;
      if ({bus.lsu_ready, bus.dbg_ready} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL wb_x0_no_block: got lrdy/drdy=%b expected 01", {bus.lsu_ready, bus.dbg_ready});
      end
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata} !== {1'b1, 5'd4, 32'h22}) begin
         tests_failed++;
         $display("[TB] FAIL wb_x0_dbg_write: got we=%b waddr=%0d wdata=%h expected 1/4/22",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata);
      end
      bus.wb_we = 1'b0;
      bus.dbg_waddr = 5'd0; bus.dbg_wdata = 32'h33;
      @(negedge clk);
      tests_run++;
      if (bus.dbg_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL dbg_x0_accept: got dbg_ready=%b expected 1", bus.dbg_ready);
      end
      tick();
      tests_run++;
      if (bus.regs_we !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL dbg_x0_no_write: got regs_we=%b expected 0", bus.regs_we);
      end
      bus.dbg_valid = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      logic [31:0] w, l;
      w = $urandom;
      l = $urandom;
      bus.wb_we = 1'b1; bus.wb_waddr = 5'd7; bus.wb_wdata = w;
      bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd8; bus.lsu_wdata = l;
      for (int i = 1; i <= STARVE_MAX + 1; i++) begin
         @(negedge clk);
         tick();
         tests_run++;
         if ({bus.lsu_ready, bus.regs_we, bus.regs_waddr, bus.regs_wdata, bus.stall_req} !==
             {1'b0, 1'b1, 5'd7, w, (i >= STARVE_MAX)}) begin
            tests_failed++;
            $display("[TB] FAIL starve_cycle[%0d]: got lrdy=%b we=%b waddr=%0d stall=%b expected 0/1/7/%b", i,
                     bus.lsu_ready, bus.regs_we, bus.regs_waddr, bus.stall_req, (i >= STARVE_MAX));
         end
      end
      bus.wb_we = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.lsu_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL starve_release: got lsu_ready=%b expected 1", bus.lsu_ready);
      end
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata, bus.stall_req} !== {1'b1, 5'd8, l, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL starve_clear: got we=%b waddr=%0d wdata=%h stall=%b expected 1/8/%h/0",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata, bus.stall_req, l);
      end
      bus.lsu_valid = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      logic [31:0] l;
      l = $urandom;
      bus.wb_we = 1'b1; bus.wb_waddr = 5'd10; bus.wb_wdata = $urandom;
      bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd9; bus.lsu_wdata = l;
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr} !== {1'b1, 5'd10}) begin
         tests_failed++;
         $display("[TB] FAIL arst_setup: got we=%b waddr=%0d expected 1/10", bus.regs_we, bus.regs_waddr);
      end
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata, bus.lsu_ready, bus.stall_req} !== 40'd0) begin
         tests_failed++;
         $display("[TB] FAIL arst_immediate: got we=%b waddr=%0d wdata=%h lrdy=%b stall=%b expected all zero",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata, bus.lsu_ready, bus.stall_req);
      end
      bus.wb_we = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus.lsu_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL arst_reaccept: got lsu_ready=%b expected 1", bus.lsu_ready);
      end
      tick();
      tests_run++;
      if ({bus.regs_we, bus.regs_waddr, bus.regs_wdata} !== {1'b1, 5'd9, l}) begin
         tests_failed++;
         $display("[TB] FAIL arst_write: got we=%b waddr=%0d wdata=%h expected 1/9/%h",
                  bus.regs_we, bus.regs_waddr, bus.regs_wdata, l);
      end
      bus.lsu_valid = 1'b0;
      tick();
   endtask

   // Random traffic against a model: 0 none, 1 LSU, 2 DBG, 3 WB
   task automatic test_random();
      int          last, win, starve;
      logic        exp_we, exp_stall, known, lsu_pend, dbg_pend, wb_act;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      drive_idle();
      rst = 1'b0;
      #2 rst = 1'b1;
      last = 2; starve = 0;
      exp_we = 1'b0; exp_stall = 1'b0; known = 1'b1;
      exp_addr = '0; exp_data = '0;
      lsu_pend = 1'b0; dbg_pend = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!lsu_pend) begin
            bus.lsu_valid = ($urandom_range(0, 9) < 6);
            bus.lsu_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.lsu_wdata = $urandom;
         end
         if (!dbg_pend) begin
            bus.dbg_valid = ($urandom_range(0, 9) < 6);
            bus.dbg_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.dbg_wdata = $urandom;
         end
         bus.wb_we    = exp_stall ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) < 6);
         bus.wb_waddr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         bus.wb_wdata = $urandom;
         wb_act = bus.wb_we && (bus.wb_waddr != 5'd0);
         if (wb_act)                               win = 3;
         else if (bus.lsu_valid && bus.dbg_valid)  win = (last == 1) ? 2 : 1;
         else if (bus.lsu_valid)                   win = 1;
         else if (bus.dbg_valid)                   win = 2;
         else                                      win = 0;
         @(negedge clk);
         tests_run++;
         if ({bus.lsu_ready, bus.dbg_ready} !== {(win == 1), (win == 2)}) begin
            tests_failed++;
            $display("[TB] FAIL rand_ready[%0d]: got lrdy/drdy=%b expected %b", cyc,
                     {bus.lsu_ready, bus.dbg_ready}, {(win == 1), (win == 2)});
         end
         lsu_pend = bus.lsu_valid && (win != 1);
         dbg_pend = bus.dbg_valid && (win != 2);
         if (win == 1 || win == 2) last = win;
         case (win)
            3: begin exp_we = 1'b1; exp_addr = bus.wb_waddr; exp_data = bus.wb_wdata; known = 1'b1; end
            1: begin
               exp_we = (bus.lsu_waddr != 5'd0);
               if (exp_we) begin exp_addr = bus.lsu_waddr; exp_data = bus.lsu_wdata; known = 1'b1; end
               else known = 1'b0;
            end
            2: begin
               exp_we = (bus.dbg_waddr != 5'd0);
               if (exp_we) begin exp_addr = bus.dbg_waddr; exp_data = bus.dbg_wdata; known = 1'b1; end
               else known = 1'b0;
            end
            default: exp_we = 1'b0;
         endcase
         if (win == 1 || win == 2 || !(bus.lsu_valid || bus.dbg_valid)) starve = 0;
         else if (wb_act && starve < STARVE_MAX) starve = starve + 1;
         exp_stall = (starve == STARVE_MAX);
         tick();
         tests_run++;
         if ({bus.regs_we, bus.stall_req} !== {exp_we, exp_stall}) begin
            tests_failed++;
            $display("[TB] FAIL rand_we_stall[%0d]: got we=%b stall=%b expected %b/%b", cyc,
                     bus.regs_we, bus.stall_req, exp_we, exp_stall);
         end
         if (known) begin
            tests_run++;
            if ({bus.regs_waddr, bus.regs_wdata} !== {exp_addr, exp_data}) begin
               tests_failed++;
               $display("[TB] FAIL rand_port[%0d]: got waddr=%0d wdata=%h expected %0d/%h", cyc,
                        bus.regs_waddr, bus.regs_wdata, exp_addr, exp_data);
            end
         end
      end
      bus.wb_we = 1'b0;
      repeat (3) tick();
      drive_idle();
      tick();
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_wb_priority();
      test_round_robin();
      test_x0();
      test_starvation();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
